bus_arbiter_4: RTL and testbench
================================

BUS_ARBITER_4 -- requirements
Module: bus_arbiter_4

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 15, max BUSY cycles before abort; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  request, bit k = requester k.
REQ-006 SHALL have port we  input  4  write enable per requester (1 write, 0 read).
REQ-007 SHALL have port addr  input  4*WIDTH  packed; requester k at [k*WIDTH +: WIDTH].
REQ-008 SHALL have port wdata  input  4*WIDTH  packed, same layout as addr.
REQ-009 SHALL have port gnt  output  4  one-hot grant, registered.
REQ-010 SHALL have port done  output  4  one-cycle completion pulse per requester.
REQ-011 SHALL have port err  output  4  one-cycle timeout pulse per requester.
REQ-012 SHALL have port sel  output  2  index of current or last granted requester.
REQ-013 SHALL have port s_valid  output  1  shared-port transaction valid.
REQ-014 SHALL have ports s_we  output  1, s_addr  output  WIDTH, s_wdata  output  WIDTH  shared-port command.
REQ-015 SHALL have ports s_ready  input  1, s_rdata  input  WIDTH  shared-port response.
REQ-016 SHALL have port rdata  output  WIDTH  registered read data of last completed read.

Function
REQ-017 SHALL implement FSM with states IDLE and BUSY.
REQ-018 IDLE: req sampled each edge; if req != 0, SHALL pick winner round-robin, searching from (ptr+1) mod 4 upward with wrap; load sel, set gnt one-hot, enter BUSY.
REQ-019 Latency: req high at edge n -> gnt and s_valid high from cycle after edge n.
REQ-020 BUSY: s_valid=1; s_we/s_addr/s_wdata SHALL be a combinational 4:1 select of requester sel's we/addr/wdata.
REQ-021 Outside BUSY: s_valid=0, s_we=0, s_addr=0, s_wdata=0.
REQ-022 req only sampled in IDLE; deasserting req while granted SHALL NOT abort the transaction; requester holds inputs stable while gnt.
REQ-023 BUSY with s_ready=1 at an edge: done[sel] pulses next cycle, rdata<=s_rdata if s_we=0 (unchanged on write), gnt<=0, ptr<=sel, state IDLE.
REQ-024 Timeout counter clears on BUSY entry, increments each BUSY cycle without s_ready; on reaching TIMEOUT: err[sel] pulse, gnt<=0, ptr<=sel, rdata unchanged, state IDLE.
REQ-025 s_ready on the same edge the counter reaches TIMEOUT: completion wins; done pulses, err does not.
REQ-026 done and err SHALL never both be nonzero; at most one bit of each set.
REQ-027 After every completion/abort at least one IDLE cycle SHALL precede the next grant.
REQ-028 gnt SHALL be zero or one-hot at all times; sel SHALL hold its value in IDLE.

Reset
REQ-029 rst_n low SHALL immediately (asynchronously) force state IDLE, gnt=0, done=0, err=0, sel=0, ptr=3, counter=0, rdata=0, s_valid=0.
REQ-030 Reset mid-BUSY SHALL drop the transaction with no done/err pulse; after release, requester 0 has first priority.

Verification
REQ-031 Reset, req=0001, we[0]=1, addr0=0x100, wdata0=0xA5, s_ready high 2 cycles after grant -> gnt=0001, s_addr=0x100, s_wdata=0xA5, s_we=1, done=0001 for exactly one cycle.
REQ-032 req=1111 held, s_ready tied 1 -> grant order 0,1,2,3,0; each transaction 2 cycles (BUSY+IDLE).
REQ-033 req=0100, we[2]=0, s_rdata=0xDEADBEEF with s_ready -> done=0100 and rdata=0xDEADBEEF in the same following cycle.
REQ-034 TIMEOUT=4, req=0010, s_ready held 0 -> err=0010 pulse after 4 BUSY cycles, no done, gnt=0, then IDLE.
REQ-035 TIMEOUT=4, s_ready asserted on the 4th BUSY cycle -> done pulses, err stays 0.
REQ-036 rst_n low mid-BUSY with grant 2 -> gnt, s_valid, sel drop to 0 without clock edge; after release with req=1111, first grant 0001.

Source files
------------

// File: rtl/bus_arbiter_4.sv
// bus_arbiter_4: four-requester round-robin arbiter in front of one shared
// request/response port, with a per-transaction timeout abort.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transaction in flight; req sampled every edge
// BUSY  | requester sel owns the shared port; waiting for s_ready/timeout
module bus_arbiter_4 #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req,
  input  logic [3:0]         we,
  input  logic [4*WIDTH-1:0] addr,
  input  logic [4*WIDTH-1:0] wdata,
  output logic [3:0]         gnt,
  output logic [3:0]         done,
  output logic [3:0]         err,
  output logic [1:0]         sel,
  output logic               s_valid,
  output logic               s_we,
  output logic [WIDTH-1:0]   s_addr,
  output logic [WIDTH-1:0]   s_wdata,
  input  logic               s_ready,
  input  logic [WIDTH-1:0]   s_rdata,
  output logic [WIDTH-1:0]   rdata
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Abort fires on the edge where the count of BUSY cycles reaches TIMEOUT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [7:0] cnt;
  logic [1:0] win;
  logic [1:0] cand;
  logic       found;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    win   = ptr;
    cand  = '0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr + 2'(i);
      if (!found && req[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  // Shared-port command: owner's inputs while BUSY, all zero otherwise.
  always_comb begin
    s_valid = (state == BUSY);
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    if (state == BUSY) begin
      case (sel)
        2'd0: begin
          s_we    = we[0];
          s_addr  = addr[0*WIDTH +: WIDTH];
          s_wdata = wdata[0*WIDTH +: WIDTH];
        end
        2'd1: begin
          s_we    = we[1];
          s_addr  = addr[1*WIDTH +: WIDTH];
          s_wdata = wdata[1*WIDTH +: WIDTH];
        end
        2'd2: begin
          s_we    = we[2];
          s_addr  = addr[2*WIDTH +: WIDTH];
          s_wdata = wdata[2*WIDTH +: WIDTH];
        end
        default: begin
          s_we    = we[3];
          s_addr  = addr[3*WIDTH +: WIDTH];
          s_wdata = wdata[3*WIDTH +: WIDTH];
        end
      endcase
    end
  end

  // Arbitration FSM with registered grant, pulses, read data and timeout count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      done  <= '0;
      err   <= '0;
      sel   <= '0;
      ptr   <= 2'd3;
      cnt   <= '0;
      rdata <= '0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= win;
            gnt   <= 4'b0001 << win;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Completion takes priority over a timeout landing on the same edge.
          if (s_ready) begin
            done <= 4'b0001 << sel;
            if (!s_we) rdata <= s_rdata;
            gnt   <= '0;
            ptr   <= sel;
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == TO_LAST) begin
            err   <= 4'b0001 << sel;
            gnt   <= '0;
            ptr   <= sel;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Testbench for bus_arbiter_4 (TIMEOUT = 4) with a transaction-level model.
module tb_bus_arbiter_4;
  localparam int W  = 32;
  localparam int TO = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req, we, gnt, done, err;
  logic [4*W-1:0] addr, wdata;
  logic [1:0]     sel;
  logic           s_valid, s_we, s_ready;
  logic [W-1:0]   s_addr, s_wdata, s_rdata, rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int last;          // last served requester (model)
  logic [W-1:0] rdata_m;

  bus_arbiter_4 #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .err(err), .sel(sel), .s_valid(s_valid),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_ready(s_ready),
    .s_rdata(s_rdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  // First requester at or after last+1 (with wrap) that is requesting.
  function automatic int pick(input int lst, input logic [3:0] rq);
    for (int k = 1; k <= 4; k++)
      if (rq[(lst + k) % 4]) return (lst + k) % 4;
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req = '0; s_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0 || done !== 4'b0 || err !== 4'b0 || sel !== 2'd0 ||
        s_valid !== 1'b0 || rdata !== '0 || s_addr !== '0 || s_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: gnt=%b done=%b err=%b sel=%0d s_valid=%b rdata=%h s_addr=%h, want all zero",
               gnt, done, err, sel, s_valid, rdata, s_addr);
    end
    rst_n = 1'b1;
    last = 3; rdata_m = '0;
  endtask

  // One transaction: drive rq, expect the model winner, assert s_ready on
  // BUSY cycle lat (lat > TO means never), optionally drop req after grant.
  task automatic do_txn(input logic [3:0] rq, input int lat, input bit drop);
    int w;
    req = rq; s_ready = 1'b0;
    @(negedge clk);
    w = pick(last, rq);
    if (w < 0) begin
      n_chk++;
      if (gnt !== 4'b0 || s_valid !== 1'b0) begin
        n_fail++; $display("FAIL no_req_grant: gnt=%b s_valid=%b want 0", gnt, s_valid);
      end
      return;
    end
    n_chk++;
    if (gnt !== (4'b1 << w) || sel !== 2'(w) || s_valid !== 1'b1 || s_we !== we[w] ||
        s_addr !== addr[w*W +: W] || s_wdata !== wdata[w*W +: W]) begin
      n_fail++;
      $display("FAIL grant: gnt=%b sel=%0d s_valid=%b s_we=%b s_addr=%h s_wdata=%h want gnt=%b sel=%0d we=%b addr=%h wdata=%h",
               gnt, sel, s_valid, s_we, s_addr, s_wdata, 4'b1 << w, w, we[w], addr[w*W +: W], wdata[w*W +: W]);
    end
    if (drop) req = '0;
    for (int k = 1; k <= TO; k++) begin
      s_ready = (k == lat);
      @(negedge clk);
      if (k == lat) begin
        if (!we[w]) rdata_m = s_rdata;
        n_chk++;
        if (done !== (4'b1 << w) || err !== 4'b0 || gnt !== 4'b0 || rdata !== rdata_m) begin
          n_fail++;
          $display("FAIL complete: done=%b err=%b gnt=%b rdata=%h want done=%b err=0 gnt=0 rdata=%h",
                   done, err, gnt, rdata, 4'b1 << w, rdata_m);
        end
        break;
      end else if (k == TO) begin
        n_chk++;
        if (err !== (4'b1 << w) || done !== 4'b0 || gnt !== 4'b0 || rdata !== rdata_m) begin
          n_fail++;
          $display("FAIL timeout: err=%b done=%b gnt=%b rdata=%h want err=%b done=0 gnt=0 rdata=%h",
                   err, done, gnt, rdata, 4'b1 << w, rdata_m);
        end
      end else begin
        n_chk++;
        if (gnt !== (4'b1 << w) || done !== 4'b0 || err !== 4'b0 || s_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_hold: gnt=%b done=%b err=%b s_valid=%b want gnt=%b, no pulses",
                   gnt, done, err, s_valid, 4'b1 << w);
        end
      end
    end
    req = '0; s_ready = 1'b0;
    last = w;
    @(negedge clk);
    n_chk++;
    if (done !== 4'b0 || err !== 4'b0 || gnt !== 4'b0 || s_valid !== 1'b0 ||
        sel !== 2'(w) || s_addr !== '0 || s_wdata !== '0) begin
      n_fail++;
      $display("FAIL idle_after: done=%b err=%b gnt=%b s_valid=%b sel=%0d s_addr=%h want zeros, sel=%0d",
               done, err, gnt, s_valid, sel, s_addr, w);
    end
  endtask

  task automatic test_basic_write();
    test_reset();
    we = 4'b0001;
    addr[0 +: W] = 32'h100; wdata[0 +: W] = 32'hA5;
    do_txn(4'b0001, 2, 1'b0);
  endtask

  task automatic test_round_robin();
    int w;
    test_reset();
    we = 4'hF; req = 4'hF; s_ready = 1'b1;
    w = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (t % 2 == 0) begin
        w = pick(last, 4'hF);
        n_chk++;
        if (gnt !== (4'b1 << w) || done !== 4'b0) begin
          n_fail++; $display("FAIL rr_grant t=%0d: gnt=%b done=%b want gnt=%b", t, gnt, done, 4'b1 << w);
        end
      end else begin
        last = w;
        n_chk++;
        if (gnt !== 4'b0 || done !== (4'b1 << w)) begin
          n_fail++; $display("FAIL rr_done t=%0d: gnt=%b done=%b want done=%b", t, gnt, done, 4'b1 << w);
        end
      end
    end
    req = '0; s_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read();
    we = 4'b0000;
    s_rdata = 32'hDEADBEEF;
    do_txn(4'b0100, 1, 1'b1);
    n_chk++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL read_rdata: rdata=%h want deadbeef", rdata);
    end
  endtask

  task automatic test_timeout();
    we = 4'b0000; s_rdata = 32'h12345678;
    do_txn(4'b0010, TO + 5, 1'b0);
  endtask

  task automatic test_ready_at_limit();
    we = 4'b0000; s_rdata = 32'hCAFEF00D;
    do_txn(4'b0010, TO, 1'b1);
  endtask

  task automatic test_reset_mid_busy();
    test_reset();
    we = 4'hF; req = 4'b0100; s_ready = 1'b0;
    @(negedge clk);
    n_chk++;
    if (gnt !== 4'b0100 || sel !== 2'd2) begin
      n_fail++; $display("FAIL mid_grant: gnt=%b sel=%0d want 0100/2", gnt, sel);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (gnt !== 4'b0 || s_valid !== 1'b0 || sel !== 2'd0 || done !== 4'b0 || err !== 4'b0) begin
      n_fail++; $display("FAIL async_reset: gnt=%b s_valid=%b sel=%0d done=%b err=%b want 0",
                         gnt, s_valid, sel, done, err);
    end
    @(negedge clk);
    rst_n = 1'b1; last = 3; rdata_m = '0;
    do_txn(4'hF, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      we = 4'($urandom_range(0, 15));
      for (int k = 0; k < 4; k++) begin
        addr[k*W +: W]  = $urandom;
        wdata[k*W +: W] = $urandom;
      end
      s_rdata = $urandom;
      do_txn(4'($urandom_range(0, 15)), $urandom_range(1, TO + 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    s_ready = 1'b0; s_rdata = '0;
    last = 3; rdata_m = '0;
    test_reset();
    test_basic_write();
    test_round_robin();
    test_read();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
